// File: rtl/token_fifo_sched.sv
// token_fifo_sched: enqueue gating, round-robin dequeue and flush sequencing for a token FIFO bank; TOKEN_FIFO_SCHED_WDOG_EN adds a consumer-stall watchdog
module token_fifo_sched #(
  parameter int N = 4,
  parameter int FLUSH_WAIT = 2,
  parameter int WDOG_LIMIT = 255,
  localparam int IW = (N < 2) ? 1 : $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  ENQ_REQ,
  output logic [N-1:0]  ENQ_RDY,
  input  logic          DEQ_RDY,
  output logic          DEQ_VALID,
  output logic [IW-1:0] DEQ_IDX,
  input  logic          FLUSH_REQ,
  output logic          FLUSH_DONE,
  output logic          STALL,
  input  logic [N-1:0]  FIFO_FULL_N,
  input  logic [N-1:0]  FIFO_EMPTY_N,
  output logic [N-1:0]  FIFO_ENQ,
  output logic [N-1:0]  FIFO_DEQ,
  output logic          FIFO_CLR
);
  typedef enum logic [1:0] {RUN, CLEAR, SETTLE} state_t;
  state_t state, nxt;
  logic [IW-1:0] ptr, idx;
  logic [N-1:0] rot;
  logic [IW:0] off;
  logic [3:0] scnt;
  logic done, run, acc;
  always_comb begin
    nxt = state;
    nxt = (state == RUN) ? (FLUSH_REQ ? CLEAR : RUN) :
          (state == CLEAR) ? ((FLUSH_WAIT > 0) ? SETTLE : RUN) :
          (scnt == 4'(FLUSH_WAIT - 1)) ? RUN : SETTLE;
  end
  // rotate so bit 0 is the channel at ptr, take the lowest set bit, rotate back
  always_comb begin
    rot = N'({FIFO_EMPTY_N, FIFO_EMPTY_N} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) off = (IW+1)'(k);
    off = off + {1'b0, ptr};
    idx = (off >= (IW+1)'(N)) ? IW'(off - (IW+1)'(N)) : off[IW-1:0];
  end
  assign run = RST && state == RUN && !FLUSH_REQ;
  assign ENQ_RDY = {N{run}} & FIFO_FULL_N;
  assign FIFO_ENQ = ENQ_REQ & ENQ_RDY;
  assign DEQ_VALID = run && |FIFO_EMPTY_N;
  assign DEQ_IDX = RST ? idx : '0;
  assign acc = DEQ_VALID && DEQ_RDY;
  assign FIFO_DEQ = acc ? (N'(1) << idx) : '0;
  assign FIFO_CLR = RST && state == CLEAR;
  assign FLUSH_DONE = RST && done;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= RUN;
      ptr <= '0;
      scnt <= '0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      scnt <= (state == SETTLE) ? scnt + 4'd1 : 4'd0;
      done <= state != RUN && nxt == RUN;
      if (acc) ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end
`ifdef TOKEN_FIFO_SCHED_WDOG_EN
  logic [15:0] wcnt, wnxt;
  logic stall;
  assign wnxt = (!DEQ_VALID || DEQ_RDY) ? 16'd0 :
                (wcnt == 16'(WDOG_LIMIT)) ? wcnt : wcnt + 16'd1;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wcnt <= '0;
      stall <= 1'b0;
    end else begin
      wcnt <= wnxt;
      stall <= (stall && !FLUSH_DONE) || wnxt == 16'(WDOG_LIMIT);
    end
  end
  assign STALL = stall;
`else
  // WDOG_LIMIT is never negative, so this is constant 0
  assign STALL = WDOG_LIMIT < 0;
`endif
endmodule

// File: tb/tb_token_fifo_sched.sv
// tb_token_fifo_sched: directed vector table, watchdog sequences and randomized run against a behavioural model
module tb_token_fifo_sched;
  localparam int N = 4, FW = 2, WL = 3;
  logic CLK = 1'b0, RST = 1'b0;
  logic [N-1:0] ENQ_REQ = '0, FIFO_FULL_N = '0, FIFO_EMPTY_N = '0;
  logic [N-1:0] ENQ_RDY, FIFO_ENQ, FIFO_DEQ;
  logic DEQ_RDY = 1'b0, FLUSH_REQ = 1'b0;
  logic DEQ_VALID, FLUSH_DONE, STALL, FIFO_CLR;
  logic [1:0] DEQ_IDX;
  int errors = 0, checks = 0;
  always #5 CLK = ~CLK;
  token_fifo_sched #(.N(N), .FLUSH_WAIT(FW), .WDOG_LIMIT(WL)) dut (
    .CLK(CLK), .RST(RST), .ENQ_REQ(ENQ_REQ), .ENQ_RDY(ENQ_RDY), .DEQ_RDY(DEQ_RDY),
    .DEQ_VALID(DEQ_VALID), .DEQ_IDX(DEQ_IDX), .FLUSH_REQ(FLUSH_REQ), .FLUSH_DONE(FLUSH_DONE),
    .STALL(STALL), .FIFO_FULL_N(FIFO_FULL_N), .FIFO_EMPTY_N(FIFO_EMPTY_N),
    .FIFO_ENQ(FIFO_ENQ), .FIFO_DEQ(FIFO_DEQ), .FIFO_CLR(FIFO_CLR)
  );
  typedef struct {
    logic rst, rdy, flush;
    logic [3:0] req, full, empty, erdy, fenq, fdeq;
    logic valid, clr, done;
    logic [1:0] idx;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] full, logic [3:0] empty,
                              logic rdy, logic flush, logic [3:0] erdy, logic [3:0] fenq,
                              logic valid, logic [1:0] idx, logic [3:0] fdeq, logic clr, logic done);
    vec_t v;
    v.rst = rst; v.req = req; v.full = full; v.empty = empty; v.rdy = rdy; v.flush = flush;
    v.erdy = erdy; v.fenq = fenq; v.valid = valid; v.idx = idx; v.fdeq = fdeq; v.clr = clr; v.done = done;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  // model state: a countdown of blocked cycles stands in for the flush sequence
  int m_ptr, m_busy, m_wrun;
  bit m_done, m_stall;
  task automatic model_step;
    logic [3:0] e_rdy, e_fdeq;
    int e_idx;
    bit found, e_run, e_valid, nd;
    found = 0;
    e_idx = 0;
    e_run = RST && m_busy == 0 && !FLUSH_REQ;
    for (int k = 0; k < N; k++)
      if (!found && FIFO_EMPTY_N[(m_ptr + k) % N]) begin
        found = 1;
        e_idx = (m_ptr + k) % N;
      end
    e_valid = e_run && found;
    e_rdy = e_run ? FIFO_FULL_N : 4'h0;
    e_fdeq = (e_valid && DEQ_RDY) ? 4'(1 << e_idx) : 4'h0;
    @(negedge CLK);
    chk("rnd enq_rdy", ENQ_RDY, e_rdy);
    chk("rnd fifo_enq", FIFO_ENQ, ENQ_REQ & e_rdy);
    chk("rnd deq_valid", DEQ_VALID, e_valid);
    chk("rnd fifo_deq", FIFO_DEQ, e_fdeq);
    if (e_valid || !RST) chk("rnd deq_idx", DEQ_IDX, RST ? e_idx : 0);
    chk("rnd fifo_clr", FIFO_CLR, RST && m_busy == FW + 1);
    chk("rnd flush_done", FLUSH_DONE, RST && m_done);
`ifdef TOKEN_FIFO_SCHED_WDOG_EN
    chk("rnd stall", STALL, m_stall);
`else
    chk("rnd stall", STALL, 0);
`endif
    chk("rnd deq_inv", FIFO_DEQ & ~FIFO_EMPTY_N, 0);
    chk("rnd enq_inv", FIFO_ENQ & ~FIFO_FULL_N, 0);
    if (!RST) begin
      m_ptr = 0; m_busy = 0; m_wrun = 0; m_done = 0; m_stall = 0;
    end else begin
      if (e_valid && DEQ_RDY) m_ptr = (e_idx + 1) % N;
      nd = m_busy == 1;
      if (m_busy > 0) m_busy--;
      else if (FLUSH_REQ) m_busy = FW + 1;
      m_wrun = (e_valid && !DEQ_RDY) ? m_wrun + 1 : 0;
      m_stall = (m_stall && !m_done) || m_wrun >= WL;
      m_done = nd;
    end
    tick();
  endtask
  initial begin
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'hF, 4'hF, 1, 0, 4'h1, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'hF, 4'hF, 1, 1, 4'h2, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'hF, 4'hF, 1, 2, 4'h4, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'hF, 4'hF, 1, 3, 4'h8, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'hF, 4'hF, 1, 0, 4'h1, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h4, 1, 0, 4'hF, 4'hF, 1, 2, 4'h4, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h4, 1, 0, 4'hF, 4'hF, 1, 2, 4'h4, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hB, 4'h0, 1, 0, 4'hB, 4'hB, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'hF, 4'hF, 1, 3, 4'h8, 0, 1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 4'hF, 4'hF, 1, 0, 4'h1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst; ENQ_REQ = tbl[i].req; FIFO_FULL_N = tbl[i].full;
      FIFO_EMPTY_N = tbl[i].empty; DEQ_RDY = tbl[i].rdy; FLUSH_REQ = tbl[i].flush;
      @(negedge CLK);
      chk($sformatf("v%0d enq_rdy", i), ENQ_RDY, tbl[i].erdy);
      chk($sformatf("v%0d fifo_enq", i), FIFO_ENQ, tbl[i].fenq);
      chk($sformatf("v%0d deq_valid", i), DEQ_VALID, tbl[i].valid);
      chk($sformatf("v%0d fifo_deq", i), FIFO_DEQ, tbl[i].fdeq);
      if (tbl[i].valid || !tbl[i].rst) chk($sformatf("v%0d deq_idx", i), DEQ_IDX, tbl[i].idx);
      chk($sformatf("v%0d fifo_clr", i), FIFO_CLR, tbl[i].clr);
      chk($sformatf("v%0d flush_done", i), FLUSH_DONE, tbl[i].done);
      tick();
    end
`ifdef TOKEN_FIFO_SCHED_WDOG_EN
    // stall for WL cycles, then clear via flush; second pass clears via reset
    for (int pass = 0; pass < 2; pass++) begin
      RST = 1'b0; FLUSH_REQ = 1'b0; ENQ_REQ = '0; FIFO_EMPTY_N = 4'h1; DEQ_RDY = 1'b0;
      tick();
      RST = 1'b1;
      for (int c = 0; c < WL + 1; c++) begin
        @(negedge CLK);
        chk($sformatf("wdog stall c%0d", c), STALL, c == WL);
        tick();
      end
      DEQ_RDY = 1'b1;
      @(negedge CLK);
      chk("wdog sticky", STALL, 1);
      tick();
      FIFO_EMPTY_N = '0;
      if (pass == 0) begin
        FLUSH_REQ = 1'b1;
        tick();
        FLUSH_REQ = 1'b0;
        for (int c = 0; c < FW + 2; c++) begin
          @(negedge CLK);
          chk($sformatf("wdog hold c%0d", c), STALL, 1);
          chk($sformatf("wdog done c%0d", c), FLUSH_DONE, c == FW + 1);
          tick();
        end
      end else begin
        RST = 1'b0;
        tick();
        RST = 1'b1;
      end
      @(negedge CLK);
      chk($sformatf("wdog cleared p%0d", pass), STALL, 0);
      tick();
    end
`endif
    RST = 1'b0; FLUSH_REQ = 1'b0;
    m_ptr = 0; m_busy = 0; m_wrun = 0; m_done = 0; m_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      RST = (i < 2) ? 1'b0 : ($urandom_range(63) != 0);
      FLUSH_REQ = ($urandom_range(15) == 0);
      ENQ_REQ = 4'($urandom);
      FIFO_FULL_N = 4'($urandom);
      FIFO_EMPTY_N = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
      DEQ_RDY = ($urandom_range(2) != 0);
      model_step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/token_fifo_sched.md
Name: token_fifo_sched

Overview:
- Controller for a bank of N depth-2, zero-data-width token FIFOs.
- Gates producer enqueues against each FIFO's FULL_N.
- Schedules one dequeue per cycle across non-empty FIFOs, round-robin, toward a single consumer.
- Sequences a bank-wide flush: CLR pulse, settle window, done pulse.
- Sits between the token FIFO bank and the credit/event logic of a multi-channel datapath.

Parameters:
- N, 4, number of token FIFOs / channels; legal range 2..16.
- FLUSH_WAIT, 2, settle cycles after the CLR pulse before accepting traffic; legal range 0..15.
- WDOG_LIMIT, 255, consumer-stall threshold in cycles for the optional watchdog; legal range 1..65535.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, synchronous, active-low.
- ENQ_REQ  in  N  producer i requests to enqueue one token to FIFO i.
- ENQ_RDY  out  N  enqueue accepted for channel i this cycle if ENQ_REQ[i] is high.
- DEQ_RDY  in  1  consumer can take one token this cycle.
- DEQ_VALID  out  1  a token is offered to the consumer this cycle.
- DEQ_IDX  out  IW  channel of the offered token; IW = max(1, clog2(N)).
- FLUSH_REQ  in  1  request a bank-wide flush.
- FLUSH_DONE  out  1  one-cycle pulse when the flush completes.
- STALL  out  1  sticky watchdog flag; tied 0 without the optional feature.
- FIFO_FULL_N  in  N  FULL_N from each FIFO.
- FIFO_EMPTY_N  in  N  EMPTY_N from each FIFO.
- FIFO_ENQ  out  N  ENQ to each FIFO.
- FIFO_DEQ  out  N  DEQ to each FIFO.
- FIFO_CLR  out  1  CLR driven to all FIFOs.

Behaviour:
- Reset (RST low at posedge): state = RUN, round-robin pointer ptr = 0, settle counter = 0, watchdog counter = 0, STALL = 0.
- While RST is low, these outputs are combinationally forced to 0: ENQ_RDY, DEQ_VALID, FIFO_ENQ, FIFO_DEQ, FIFO_CLR, FLUSH_DONE. DEQ_IDX = 0.
- FSM states:
  - RUN: normal traffic.
  - CLEAR: exactly 1 cycle; FIFO_CLR = 1.
  - SETTLE: FLUSH_WAIT cycles.
- Transitions:
  - RUN -> CLEAR when FLUSH_REQ = 1.
  - CLEAR -> SETTLE if FLUSH_WAIT > 0, otherwise CLEAR -> RUN.
  - SETTLE -> RUN when the settle counter reaches FLUSH_WAIT - 1.
- FLUSH_DONE pulses high for 1 cycle on the first RUN cycle after CLEAR or SETTLE.
- FLUSH_REQ is ignored outside RUN; it is level-sampled, so a request held high re-flushes after FLUSH_DONE.
- Enqueue path, combinational, zero latency:
  - ENQ_RDY[i] = (state == RUN) & !FLUSH_REQ & FIFO_FULL_N[i].
  - FIFO_ENQ[i] = ENQ_REQ[i] & ENQ_RDY[i].
- Dequeue path, combinational offer:
  - DEQ_VALID = (state == RUN) & !FLUSH_REQ & |FIFO_EMPTY_N.
  - DEQ_IDX = first index j with FIFO_EMPTY_N[j] = 1, searching ptr, ptr+1, ... with wrap from N-1 to 0.
  - FIFO_DEQ[DEQ_IDX] = DEQ_VALID & DEQ_RDY; exactly one-hot or zero.
- Pointer update: on an accepted dequeue, ptr <= DEQ_IDX + 1, wrapping N-1 -> 0 (N need not be a power of 2). Otherwise ptr holds. Flush does not reset ptr.
- Simultaneous enqueue and dequeue on the same channel is legal and passed through; FIFO occupancy is unchanged.
- A FLUSH_REQ cycle suppresses all enqueues and dequeues in that same cycle; flush wins.
- Invariant: never assert FIFO_DEQ[i] while FIFO_EMPTY_N[i] = 0, and never assert FIFO_ENQ[i] while FIFO_FULL_N[i] = 0.
- Mid-operation reset: any state returns to RUN next cycle with ptr = 0; no FLUSH_DONE pulse is issued.

Optional Feature:
- Macro: TOKEN_FIFO_SCHED_WDOG_EN.
- Defined:
  - A 16-bit counter increments on each cycle with DEQ_VALID & !DEQ_RDY.
  - The counter clears on any accepted dequeue, or when DEQ_VALID = 0.
  - When the counter reaches WDOG_LIMIT, STALL sets to 1 and stays set until reset or FLUSH_DONE.
  - The counter saturates at WDOG_LIMIT.
- Undefined: no counter is built; STALL is constant 0.

Test Plan:
- Reset: hold RST = 0 for 3 cycles with all FIFO_EMPTY_N = 1 and DEQ_RDY = 1 -> DEQ_VALID = 0, FIFO_DEQ = 0 throughout. First cycle after release: DEQ_IDX = 0.
- Round-robin, N = 4: FIFO_EMPTY_N = 4'b1111, DEQ_RDY = 1 for 5 cycles -> DEQ_IDX sequence 0, 1, 2, 3, 0. Then FIFO_EMPTY_N = 4'b0100 -> DEQ_IDX = 2 each cycle.
- Full gating: FIFO_FULL_N = 4'b1011, ENQ_REQ = 4'b1111 -> FIFO_ENQ = 4'b1011, ENQ_RDY[2] = 0.
- Flush, FLUSH_WAIT = 2: 1-cycle FLUSH_REQ pulse at cycle t with requests active ->
  - Cycle t: no ENQ or DEQ.
  - Cycle t+1: FIFO_CLR = 1.
  - Cycles t+2, t+3: ENQ_RDY = 0, DEQ_VALID = 0.
  - Cycle t+4: FLUSH_DONE = 1, traffic resumes.
- Reset mid-SETTLE: assert RST = 0 at cycle t+2 of the flush -> state RUN, no FLUSH_DONE pulse, ptr = 0.
- Watchdog, macro defined, WDOG_LIMIT = 3: DEQ_VALID = 1 and DEQ_RDY = 0 for 3 cycles -> STALL = 1 from the next cycle. STALL stays 1 after DEQ_RDY returns, and clears only on flush or reset.
